// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the sequence-detector frame controller.
// Holds the FSM state encoding and the default frame and counter sizes.
package seq_detect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int DEF_FRAME_LEN = 8;
    localparam int DEF_CNT_W     = 4;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register, MSB first; zeros fill from the LSB end
// so the output naturally falls to 0 once the frame has been shifted out.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign sreg_d[gi] = load ? data[gi] : (shift ? 1'b0 : sreg_q[gi]);
            end else begin : g_upper
                assign sreg_d[gi] = load ? data[gi] : (shift ? sreg_q[gi-1] : sreg_q[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign msb = sreg_q[WIDTH-1];

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame controller: serialises a parallel frame into an external Moore
// sequence detector and counts the matches it reports during the frame.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [FRAME_LEN-1:0] data,
    input  logic                 z_in,
    output logic                 x_out,
    output logic                 btn_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     match_cnt
);

    localparam int                IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               btn_q;
    logic               busy_q;
    logic               done_q;

    logic               accept;
    logic               shift_en;
    logic               count_en;
    logic               msb;

    assign accept   = (state_q == ST_IDLE) && start;
    assign shift_en = (state_q == ST_SHIFT);

    // The detector answers one cycle late: z during bit 0 belongs to the
    // previous traffic, and the last bit's answer arrives during WAIT.
    assign count_en = z_in && (((state_q == ST_SHIFT) && (idx_q != '0)) ||
                               (state_q == ST_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    piso_shift #(
        .WIDTH (FRAME_LEN)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift_en),
        .data  (data),
        .msb   (msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SHIFT;
                        idx_q   <= '0;
                        btn_q   <= mode;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_WAIT;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_WAIT: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The shift register empties itself, so its MSB is already 0 outside SHIFT.
    assign x_out     = msb;
    assign btn_out   = btn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl driving a behavioural Moore
// detector for 110010 / 110110; a second instance checks counter saturation.
module tb_seq_detect_ctrl;

    localparam int FL = 8;

    typedef struct {
        logic x;
        logic btn;
    } bit_exp_t;

    typedef struct {
        int   cnt;
        int   done_edge;
        logic btn;
    } frame_exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          start2 = 1'b0;
    logic          mode = 1'b0;
    logic [FL-1:0] data = '0;
    logic          force_z = 1'b0;
    logic          z_in;
    logic          x_out, btn_out, busy, done;
    logic [3:0]    match_cnt;
    logic          x2, btn2, busy2, done2;
    logic [1:0]    cnt2;

    logic [5:0]    hist;
    logic          det_z;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int bcnt = 0;

    bit_exp_t   xq[$];
    frame_exp_t fq[$];

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural Moore detector: its state is the last six bits it received.
    always @(posedge clk) begin
        if (rst) hist <= '0;
        else     hist <= {hist[4:0], x_out};
    end
    assign det_z = btn_out ? (hist == 6'b110010) : (hist == 6'b110110);
    assign z_in  = force_z | det_z;

    seq_detect_ctrl #(.FRAME_LEN(FL), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .data(data),
        .z_in(z_in), .x_out(x_out), .btn_out(btn_out), .busy(busy),
        .done(done), .match_cnt(match_cnt)
    );

    seq_detect_ctrl #(.FRAME_LEN(FL), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode), .data(data),
        .z_in(1'b1), .x_out(x2), .btn_out(btn2), .busy(busy2),
        .done(done2), .match_cnt(cnt2)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push_exp(input logic [FL-1:0] d, input logic m, input int cnt,
                            input int acc_edge, input bit with_frame);
        bit_exp_t b;
        frame_exp_t f;
        for (int i = 0; i < FL; i++) begin
            b.x = d[FL-1-i];
            b.btn = m;
            xq.push_back(b);
        end
        b.x = 1'b0;
        b.btn = m;
        xq.push_back(b);
        if (with_frame) begin
            f.cnt = cnt;
            f.done_edge = acc_edge + FL + 1;
            f.btn = m;
            fq.push_back(f);
        end
    endtask

    // Issues one start pulse from IDLE; returns one step after the accepting edge.
    task automatic run_frame(input logic [FL-1:0] d, input logic m, input int cnt,
                             input bit with_frame);
        data = d;
        mode = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(d, m, cnt, edge_cnt, with_frame);
        $display("frame: data=%02h mode=%0d accepted at edge %0d exp_cnt=%0d",
                 d, m, edge_cnt, cnt);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk(name, busy, 0);
    endtask

    // Monitor: per-bit checks while the frame is on the wire, frame checks on done.
    always @(negedge clk) begin
        bit_exp_t b;
        frame_exp_t f;
        if (busy) begin
            if (bcnt <= FL) begin
                if (xq.size() == 0) begin
                    chk("bit_queue_empty", 1, 0);
                end else begin
                    b = xq.pop_front();
                    chk("x_out", x_out, b.x);
                    chk("btn_out", btn_out, b.btn);
                end
            end
            bcnt++;
        end else begin
            bcnt = 0;
        end
        if (done) begin
            if (fq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                f = fq.pop_front();
                chk("match_cnt", match_cnt, f.cnt);
                chk("done_edge", edge_cnt, f.done_edge);
                chk("done_btn", btn_out, f.btn);
                $display("done: edge=%0d match_cnt=%0d btn=%0d", edge_cnt, match_cnt, btn_out);
            end
        end
    end

    initial begin
        int n;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_x_out", x_out, 0);
        chk("rst_btn_out", btn_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_dut2_busy", busy2, 0);
        chk("rst_dut2_x_btn_done", {x2, btn2, done2}, 0);
        chk("rst_dut2_cnt", cnt2, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 8'hC8 with pattern 110010: one match.
        run_frame(8'hC8, 1'b1, 1, 1'b1);
        wait_idle("idle_after_c8");

        // z in IDLE must not move the held count.
        force_z = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force_z = 1'b0;
        chk("idle_hold_cnt", match_cnt, 1);

        // 8'hDB with pattern 110110: one match; the trailing WAIT zero makes a
        // match visible only in DONE, which must be ignored.
        @(posedge clk); #1;
        run_frame(8'hDB, 1'b0, 1, 1'b1);
        wait_idle("idle_after_db");

        // z stuck high: bits 1..7 plus WAIT -> 8 counts.
        @(posedge clk); #1;
        force_z = 1'b1;
        run_frame(8'hA5, 1'b0, 8, 1'b1);
        wait_idle("idle_after_forced");
        force_z = 1'b0;

        // Two-bit counter with z tied high saturates at 3.
        data = 8'h3C;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (done2) seen = 1'b1;
        end
        chk("dut2_done_seen", seen, 1);
        chk("dut2_sat_cnt", cnt2, 3);
        $display("dut2: done_seen=%0d match_cnt=%0d", seen, cnt2);
        repeat (2) @(posedge clk);
        #1;
        chk("dut2_idle_hold", {busy2, cnt2}, 3);

        // Extra starts at N+3 and N+9 plus a mode flip mid-frame are ignored.
        run_frame(8'hC8, 1'b1, 1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("idle_after_ignored_starts");
        repeat (3) @(posedge clk);
        #1;
        chk("no_relaunch_busy", busy, 0);
        mode = 1'b1;

        // Reset at N+5 aborts: count 3 just before, everything cleared after.
        force_z = 1'b1;
        run_frame(8'hFF, 1'b1, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_abort_cnt", match_cnt, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        force_z = 1'b0;
        xq.delete();
        chk("abort_busy", busy, 0);
        chk("abort_x_out", x_out, 0);
        chk("abort_match_cnt", match_cnt, 0);
        chk("abort_done", done, 0);
        $display("abort: busy=%0d x_out=%0d match_cnt=%0d", busy, x_out, match_cnt);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_stays_idle", busy, 0);

        // start held high: three frames, done pulses FL+3 edges apart.
        data = 8'hC8;
        mode = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        n = edge_cnt;
        for (int k = 0; k < 3; k++) begin
            push_exp(8'hC8, 1'b1, 1, n + k * (FL + 3), 1'b1);
            $display("frame: data=c8 mode=1 held start, acceptance edge %0d", n + k * (FL + 3));
        end
        repeat (2 * (FL + 3)) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("idle_after_back_to_back");

        repeat (4) @(posedge clk);
        #1;
        chk("bit_queue_drained", xq.size(), 0);
        chk("frame_queue_drained", fq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, meaning the number of serial bits per frame (range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the match counter width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, meaning a frame request, sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 1, meaning the pattern select for the frame (1 = 110010, 0 = 110110).
REQ-007 The block SHALL have port data, input, FRAME_LEN, meaning the frame bits, MSB sent first.
REQ-008 The block SHALL have port z_in, input, 1, meaning the detector match output (Moore, valid one cycle after its input bit).
REQ-009 The block SHALL have port x_out, output, 1, meaning the serial bit driven to the detector.
REQ-010 The block SHALL have port btn_out, output, 1, meaning the latched mode driven to the detector.
REQ-011 The block SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-012 The block SHALL have port done, output, 1, meaning a one-cycle pulse at the end of a frame.
REQ-013 The block SHALL have port match_cnt, output, CNT_W, meaning the matches counted in the last or current frame.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT, WAIT and DONE, all registered.
REQ-015 In IDLE with start=1, the block SHALL latch data into the shift register and mode into btn_out, clear match_cnt and go to SHIFT on the same edge.
REQ-016 In SHIFT, x_out SHALL equal the shift register MSB, the register SHALL shift left by one per cycle, and a bit index SHALL count 0..FRAME_LEN-1.
REQ-017 After the cycle with bit index FRAME_LEN-1, the FSM SHALL go to WAIT for exactly one cycle with x_out=0, so the last bit's z_in is observed.
REQ-018 WAIT SHALL always go to DONE; DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-019 match_cnt SHALL increment on each edge where z_in=1 and either the state is SHIFT with bit index >=1, or the state is WAIT; z_in SHALL be ignored in all other states.
REQ-020 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 match_cnt SHALL hold its value through IDLE until the next accepted start.
REQ-022 busy SHALL be 1 in SHIFT, WAIT and DONE, and 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored, with no queueing.
REQ-024 btn_out SHALL remain constant for the whole frame, even if mode changes mid-frame.
REQ-025 Latency SHALL be: start accepted at edge N -> first bit on x_out in cycle N+1 -> done high in cycle N+FRAME_LEN+2.
REQ-026 start held high continuously SHALL launch back-to-back frames, each separated by one IDLE cycle.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set the state to IDLE, x_out=0, btn_out=0, busy=0, done=0, match_cnt=0, and clear the shift register and bit index.
REQ-028 Reset mid-frame SHALL abort the frame with no done pulse; rst SHALL take priority over start on the same edge.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'b00, SHIFT=2'b01, WAIT=2'b10, DONE=2'b11) and the default FRAME_LEN and CNT_W.
REQ-030 The parallel-in serial-out register SHALL be one sub-module, piso_shift (load, shift, msb); the FSM and counter SHALL stay in seq_detect_ctrl.

Verification
REQ-031 Bench SHALL cover: reset, then data=8'hC8, mode=1, start pulse, with a behavioural detector model starting in its initial state -> x_out sequence 1,1,0,0,1,0,0,0; match_cnt=1; done one cycle in cycle N+10.
REQ-032 Bench SHALL cover: data=8'hDB (11011011), mode=0 -> 110110 detected once; match_cnt=1; btn_out=0 throughout the frame.
REQ-033 Bench SHALL cover: z_in forced to 1 for all cycles, CNT_W=2 -> match_cnt saturates at 3, not 0.
REQ-034 Bench SHALL cover: start asserted again in cycles N+3 and N+9, and mode toggled mid-frame -> both ignored; btn_out unchanged; single done pulse.
REQ-035 Bench SHALL cover: rst=1 in cycle N+5 -> next cycle state IDLE, busy=0, x_out=0, match_cnt=0, and no done pulse.
REQ-036 Bench SHALL cover: start held high for 3 frames -> three done pulses spaced FRAME_LEN+3 cycles apart.
